// File: rtl/left_shift_unit.sv
// left_shift_unit: multicycle 32-bit left shifter / rotator.
// Applies one barrel stage (16, 8, 4, 2, 1) per clock after a start pulse,
// then presents the result with a one-cycle ready pulse and a sticky
// overflow flag (bits lost off the top in logical mode).
//
// Ports:
//   clock           system clock, rising edge
//   reset_n         asynchronous active-low reset
//   ctrl_SLL        start pulse (accepted in IDLE or DONE)
//   ctrl_rotate     mode sampled with start: 0 = logical, 1 = rotate
//   data_operandA   value to shift
//   data_shamt      shift amount 0..31
//   data_result     shifted value, held until the next accepted start
//   data_resultRDY  one-cycle result-valid pulse
//   data_exception  logical mode: a 1 bit was shifted out of bit 31
//   busy            high while stages are being applied
module left_shift_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_SLL,
  input  logic        ctrl_rotate,
  input  logic [31:0] data_operandA,
  input  logic [4:0]  data_shamt,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        data_exception,
  output logic        busy
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned STAGE_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [DATA_W-1:0]    acc, acc_nxt;
  logic [SHAMT_W-1:0]   amt, amt_nxt;
  logic                 mode, mode_nxt;
  logic [STAGE_W-1:0]   stage, stage_nxt;
  logic                 exc, exc_nxt;
  logic                 rdy, rdy_nxt;
  logic                 busy_q, busy_nxt;

  logic [SHAMT_W-1:0]   step_c;
  logic [2*DATA_W-1:0]  ext_c;

  // Stage index to shift distance (2^stage).
  always_comb begin
    step_c = SHAMT_W'(0);
    case (stage)
      3'd4:    step_c = SHAMT_W'(16);
      3'd3:    step_c = SHAMT_W'(8);
      3'd2:    step_c = SHAMT_W'(4);
      3'd1:    step_c = SHAMT_W'(2);
      3'd0:    step_c = SHAMT_W'(1);
      default: step_c = SHAMT_W'(0);
    endcase
  end

  // Widened shift: low half is the zero-filled result, high half holds the
  // bits pushed out of bit 31 (reused as rotate wrap-around and overflow).
  always_comb begin
    ext_c = {DATA_W'(0), acc} << step_c;
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      acc    <= DATA_W'(0);
      amt    <= SHAMT_W'(0);
      mode   <= 1'b0;
      stage  <= STAGE_W'(0);
      exc    <= 1'b0;
      rdy    <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      amt    <= amt_nxt;
      mode   <= mode_nxt;
      stage  <= stage_nxt;
      exc    <= exc_nxt;
      rdy    <= rdy_nxt;
      busy_q <= busy_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    amt_nxt   = amt;
    mode_nxt  = mode;
    stage_nxt = stage;
    exc_nxt   = exc;
    rdy_nxt   = 1'b0;
    busy_nxt  = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (ctrl_SLL) begin
          acc_nxt   = data_operandA;
          amt_nxt   = data_shamt;
          mode_nxt  = ctrl_rotate;
          exc_nxt   = 1'b0;
          stage_nxt = STAGE_W'(4);
          state_nxt = (data_shamt == SHAMT_W'(0)) ? DONE : SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        // Starts arriving here are dropped; the op always takes 5 stages.
        if (amt[stage]) begin
          if (mode) begin
            acc_nxt = ext_c[DATA_W-1:0] | ext_c[2*DATA_W-1:DATA_W];
          end else begin
            acc_nxt = ext_c[DATA_W-1:0];
            exc_nxt = exc | (|ext_c[2*DATA_W-1:DATA_W]);
          end
        end
        if (stage == STAGE_W'(0)) begin
          state_nxt = DONE;
        end else begin
          stage_nxt = stage - STAGE_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    rdy_nxt  = (state_nxt == DONE);
    busy_nxt = (state_nxt == SHIFT);
  end

  assign data_result    = acc;
  assign data_exception = exc;
  assign data_resultRDY = rdy;
  assign busy           = busy_q;

endmodule

// File: tb/tb_left_shift_unit.sv
// Directed testbench for left_shift_unit.
module tb_left_shift_unit;

  logic        clock;
  logic        reset_n;
  logic        ctrl_SLL;
  logic        ctrl_rotate;
  logic [31:0] data_operandA;
  logic [4:0]  data_shamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        data_exception;
  logic        busy;

  int total;
  int passed;

  localparam int MAX_LAT = 20;

  left_shift_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_SLL       (ctrl_SLL),
    .ctrl_rotate    (ctrl_rotate),
    .data_operandA  (data_operandA),
    .data_shamt     (data_shamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one start and wait (bounded) for the ready pulse.
  // lat = number of rising edges from the accepting edge to the RDY cycle.
  task automatic run_op(input logic [31:0] a, input logic [4:0] sh, input logic rot,
                        output int busy_cycles, output int lat,
                        output logic [31:0] res, output logic exc);
    data_operandA = a;
    data_shamt    = sh;
    ctrl_rotate   = rot;
    ctrl_SLL      = 1'b1;
    tick();
    ctrl_SLL      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_shamt    = 5'd7;
    lat = 1;
    busy_cycles = 0;
    while (data_resultRDY !== 1'b1 && lat < MAX_LAT) begin
      if (busy === 1'b1) busy_cycles++;
      tick();
      lat++;
    end
    res = data_result;
    exc = data_exception;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    total++; if (data_result !== 32'h0) $display("FAIL reset_result got=%h exp=%h", data_result, 32'h0); else passed++;
    total++; if (data_resultRDY !== 1'b0) $display("FAIL reset_rdy got=%b exp=0", data_resultRDY); else passed++;
    total++; if (data_exception !== 1'b0) $display("FAIL reset_exc got=%b exp=0", data_exception); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_logical_max();
    int bc, lat; logic [31:0] res; logic exc;
    run_op(32'h0000_0001, 5'd31, 1'b0, bc, lat, res, exc);
    total++; if (bc !== 5) $display("FAIL max_busy_cycles got=%0d exp=5", bc); else passed++;
    total++; if (lat !== 6) $display("FAIL max_latency got=%0d exp=6", lat); else passed++;
    total++; if (res !== 32'h8000_0000) $display("FAIL max_result got=%h exp=%h", res, 32'h8000_0000); else passed++;
    total++; if (exc !== 1'b0) $display("FAIL max_exc got=%b exp=0", exc); else passed++;
    tick();
    total++; if (data_resultRDY !== 1'b0) $display("FAIL max_rdy_pulse got=%b exp=0", data_resultRDY); else passed++;
    total++; if (data_result !== 32'h8000_0000) $display("FAIL max_hold got=%h exp=%h", data_result, 32'h8000_0000); else passed++;
  endtask

  task automatic test_overflow_rotate();
    int bc, lat; logic [31:0] res; logic exc;
    run_op(32'hF000_000F, 5'd4, 1'b0, bc, lat, res, exc);
    total++; if (res !== 32'h0000_00F0) $display("FAIL ovf_result got=%h exp=%h", res, 32'h0000_00F0); else passed++;
    total++; if (exc !== 1'b1) $display("FAIL ovf_exc got=%b exp=1", exc); else passed++;
    tick();
    run_op(32'hF000_000F, 5'd4, 1'b1, bc, lat, res, exc);
    total++; if (res !== 32'h0000_00FF) $display("FAIL rot4_result got=%h exp=%h", res, 32'h0000_00FF); else passed++;
    total++; if (exc !== 1'b0) $display("FAIL rot4_exc got=%b exp=0", exc); else passed++;
    tick();
    run_op(32'h8000_0001, 5'd1, 1'b1, bc, lat, res, exc);
    total++; if (res !== 32'h0000_0003) $display("FAIL rot1_result got=%h exp=%h", res, 32'h0000_0003); else passed++;
    total++; if (exc !== 1'b0) $display("FAIL rot1_exc got=%b exp=0", exc); else passed++;
    tick();
    run_op(32'h1234_5678, 5'd12, 1'b1, bc, lat, res, exc);
    total++; if (res !== 32'h4567_8123) $display("FAIL rot12_result got=%h exp=%h", res, 32'h4567_8123); else passed++;
    tick();
  endtask

  task automatic test_zero_shamt();
    int bc, lat; logic [31:0] res; logic exc;
    run_op(32'h1234_5678, 5'd0, 1'b0, bc, lat, res, exc);
    total++; if (lat !== 1) $display("FAIL zero_latency got=%0d exp=1", lat); else passed++;
    total++; if (busy !== 1'b0 || bc !== 0) $display("FAIL zero_busy got=%b/%0d exp=0/0", busy, bc); else passed++;
    total++; if (res !== 32'h1234_5678) $display("FAIL zero_result got=%h exp=%h", res, 32'h1234_5678); else passed++;
    total++; if (exc !== 1'b0) $display("FAIL zero_exc got=%b exp=0", exc); else passed++;
    tick();
  endtask

  task automatic test_ignored_start();
    int rdy_cnt;
    data_operandA = 32'h0000_0001;
    data_shamt    = 5'd5;
    ctrl_rotate   = 1'b0;
    ctrl_SLL      = 1'b1;
    tick();
    ctrl_SLL = 1'b0;
    tick();
    data_operandA = 32'hFFFF_FFFF;
    data_shamt    = 5'd3;
    ctrl_SLL      = 1'b1;
    tick();
    ctrl_SLL = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (data_resultRDY === 1'b1) begin
        rdy_cnt++;
        total++; if (data_result !== 32'h0000_0020) $display("FAIL ignore_result got=%h exp=%h", data_result, 32'h0000_0020); else passed++;
        total++; if (data_exception !== 1'b0) $display("FAIL ignore_exc got=%b exp=0", data_exception); else passed++;
      end
      tick();
    end
    total++; if (rdy_cnt !== 1) $display("FAIL ignore_rdy_count got=%0d exp=1", rdy_cnt); else passed++;
  endtask

  task automatic test_reset_abort();
    int bc, lat, rdy_cnt; logic [31:0] res; logic exc;
    data_operandA = 32'h0000_0001;
    data_shamt    = 5'd8;
    ctrl_rotate   = 1'b0;
    ctrl_SLL      = 1'b1;
    tick();
    ctrl_SLL = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b1 || data_result !== 32'h0000_0100) $display("FAIL abort_pre got=%b/%h exp=1/%h", busy, data_result, 32'h0000_0100); else passed++;
    reset_n = 1'b0;
    #1;
    total++; if (data_result !== 32'h0 || busy !== 1'b0 || data_resultRDY !== 1'b0 || data_exception !== 1'b0)
      $display("FAIL abort_async got=%h/%b/%b/%b exp=0/0/0/0", data_result, busy, data_resultRDY, data_exception); else passed++;
    rdy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (data_resultRDY === 1'b1) rdy_cnt++;
      tick();
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (data_resultRDY === 1'b1) rdy_cnt++;
      tick();
    end
    total++; if (rdy_cnt !== 0) $display("FAIL abort_no_rdy got=%0d exp=0", rdy_cnt); else passed++;
    run_op(32'h0000_0003, 5'd2, 1'b0, bc, lat, res, exc);
    total++; if (res !== 32'h0000_000C || lat !== 6) $display("FAIL abort_after got=%h/%0d exp=%h/6", res, lat, 32'h0000_000C); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    data_operandA = 32'h0000_0001;
    data_shamt    = 5'd4;
    ctrl_rotate   = 1'b0;
    ctrl_SLL      = 1'b1;
    tick();
    ctrl_SLL = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (data_resultRDY !== 1'b1 || data_result !== 32'h0000_0010) $display("FAIL b2b_first got=%b/%h exp=1/%h", data_resultRDY, data_result, 32'h0000_0010); else passed++;
    data_operandA = 32'hAAAA_AAAA;
    data_shamt    = 5'd1;
    ctrl_SLL      = 1'b1;
    tick();
    ctrl_SLL = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_accept got=%b exp=1", busy); else passed++;
    lat = 1;
    while (data_resultRDY !== 1'b1 && lat < MAX_LAT) begin
      tick();
      lat++;
    end
    total++; if (lat !== 6) $display("FAIL b2b_latency got=%0d exp=6", lat); else passed++;
    total++; if (data_result !== 32'h5555_5554) $display("FAIL b2b_result got=%h exp=%h", data_result, 32'h5555_5554); else passed++;
    total++; if (data_exception !== 1'b1) $display("FAIL b2b_exc got=%b exp=1", data_exception); else passed++;
    tick();
  endtask

  initial begin
    total         = 0;
    passed        = 0;
    ctrl_SLL      = 1'b0;
    ctrl_rotate   = 1'b0;
    data_operandA = 32'h0;
    data_shamt    = 5'd0;
    test_reset();
    test_logical_max();
    test_overflow_rotate();
    test_zero_shamt();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/left_shift_unit.md
# left_shift_unit

Multicycle 32-bit left shifter for the processor's shift datapath: the sequential, left-direction companion to the combinational right barrel shifter. It accepts an operand and 5-bit shift amount on a start pulse and resolves one barrel stage (16, 8, 4, 2, 1) per clock. It returns the result with a one-cycle ready pulse and a sticky overflow flag, so the execute stage can stall on it the same way it stalls on multiply/divide.

## Interface
Parameters: none. Width fixed at 32, shamt fixed at 5.
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset; clears all state immediately on assertion
- ctrl_SLL  in  1  start pulse; samples operand, shamt, mode on the rising edge where high
- ctrl_rotate  in  1  sampled with ctrl_SLL: 0 = logical left shift (zero fill), 1 = rotate left
- data_operandA  in  32  value to shift
- data_shamt  in  5  shift amount 0..31
- data_result  out  32  shifted value; valid while data_resultRDY high, held until next accepted start
- data_resultRDY  out  1  one-cycle pulse, result valid
- data_exception  out  1  valid with data_resultRDY: logical mode, any 1 bit shifted out of bit 31; rotate mode, always 0
- busy  out  1  high while stages are being applied (state SHIFT)

## Operation
- States: IDLE, SHIFT, DONE. Registers: acc[31:0], amt[4:0], mode, stage[2:0], exc.
- Start is accepted in IDLE or DONE when ctrl_SLL=1. It is ignored in SHIFT (no queueing, no effect on the in-flight op).
- On accept: acc<=data_operandA, amt<=data_shamt, mode<=ctrl_rotate, exc<=0, stage<=4.
  - If data_shamt==0, go to DONE.
  - Otherwise, go to SHIFT.
- SHIFT, each cycle, with k=stage:
  - If amt[k]=1: acc<=acc<<(2^k) in logical mode (low bits zero), or acc<={acc[31-2^k:0],acc[31:32-2^k]} in rotate mode.
  - In logical mode, exc<=exc | (OR of acc[31:32-2^k]) when amt[k]=1.
  - If amt[k]=0: acc and exc unchanged.
  - If stage==0, go to DONE; else stage<=stage-1.
  - Fixed 5 cycles regardless of amt bit pattern. No early exit.
- DONE: data_resultRDY=1 for exactly this cycle.
  - Next state is SHIFT or DONE on a new accepted start (same rules as IDLE); otherwise IDLE.
- data_result is driven from acc at all times and holds its value through IDLE.
- data_exception is driven from exc at all times.
- Result equals (A<<shamt) mod 2^32 in logical mode, and rotl32(A,shamt) in rotate mode.

## Timing
- Reset values: data_result=0, data_resultRDY=0, data_exception=0, busy=0, state=IDLE.
- Let edge E0 be the rising edge sampling ctrl_SLL=1.
  - shamt!=0: busy high in the cycles after E0..E4. Stages 16,8,4,2,1 are applied at E1..E5. data_resultRDY is high in the cycle after E5 (latency 6 edges).
  - shamt==0: data_resultRDY is high in the cycle after E0, with data_result=A and data_exception=0 (latency 1).
- Back-to-back: start sampled on the DONE cycle's edge is accepted. Throughput is 1 op per 6 cycles (shamt!=0).
- Operand, shamt and mode inputs are don't-care except on the accepting edge.
- reset_n asserted mid-SHIFT or in DONE: outputs drop to reset values asynchronously. No RDY pulse is produced for the aborted op. After reset_n deasserts, the first rising edge behaves as IDLE.
- Outputs are registered. No combinational path from any input to any output.

## Test plan
- A=0x00000001, shamt=31, rotate=0 -> busy for 5 cycles; RDY pulse on 6th cycle after start; result=0x80000000, exception=0.
- A=0xF000000F, shamt=4, rotate=0 -> result=0x000000F0, exception=1. Same A with rotate=1 -> result=0x000000FF, exception=0.
- A=0x80000001, shamt=1, rotate=1 -> 0x00000003. A=0x12345678, shamt=0 -> RDY on cycle after start, result=0x12345678, busy never high.
- Start with A=0x1, shamt=5; pulse ctrl_SLL again two cycles later with A=0xFFFFFFFF -> second start ignored; result=0x00000020; exactly one RDY pulse.
- Start A=0x1, shamt=8; assert reset_n=0 on 3rd SHIFT cycle -> all outputs 0 immediately, no RDY. After release, start A=0x3, shamt=2 -> result=0x0000000C.
- Back-to-back: ctrl_SLL high on the DONE cycle with A=0xAAAAAAAA, shamt=1 -> first RDY observed, second op accepted, second result=0x55555554, exception=1.
